mem_port_arbiter: RTL

- Shares one single-ported unified memory between the instruction-fetch (IF) requester and the data (MEM-stage) requester.
- Sequences each access through issue, fixed-latency wait and response phases.
- Converts the controller's width codes into byte enables and lane extraction, with sign extension.
- The pipeline stalls a requester until its one-cycle ready pulse.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two pipeline requesters, the arbiter and the unified memory.
// Handshake: a requester raises its request and holds it and its operands stable until its
// one-cycle ready pulse; ready only ever pulses for a granted request, and the memory sees one
// mem_en strobe per transaction with mem_rdata valid MEM_LAT cycles later.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_width;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        d_misalign;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, d_width, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, d_misalign,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_ren, d_wen, d_addr, d_wdata, d_width, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, d_misalign,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data accesses,
// sequencing each access through ISSUE, a fixed-latency WAIT and a one-cycle RESP.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 4,
  localparam int SW = $clog2(STARVE_MAX + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]    dbg_state,
  output logic [SW-1:0] dbg_starve
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [CW-1:0] wait_cnt;
  logic          r_is_d;
  logic          r_we;
  logic [1:0]    r_width;
  logic [1:0]    r_lane;

  logic        d_req, starved, grant_d, grant_if, grant_we, misalign;
  logic        is_half, is_byte, is_word;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] rd_ext;

  assign dbg_state  = state;
  assign dbg_starve = starve_cnt;

  // Data normally wins (older instruction); a starved fetch gets exactly one grant.
  assign d_req    = bus.d_ren | bus.d_wen;
  assign starved  = (starve_cnt == SW'(STARVE_MAX)) && bus.if_req;
  assign grant_d  = d_req && !starved;
  assign grant_if = bus.if_req && !grant_d;
  assign grant_we = grant_d && bus.d_wen;

  assign is_half  = (bus.d_width == 2'd1);
  assign is_byte  = (bus.d_width == 2'd2);
  assign is_word  = !is_half && !is_byte;
  assign misalign = (is_half && bus.d_addr[0]) || (is_word && (bus.d_addr[1:0] != 2'b00));

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = bus.d_wdata;
    if (is_half) begin
      wr_be   = bus.d_addr[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{bus.d_wdata[15:0]}};
    end else if (is_byte) begin
      wr_be   = 4'b0001 << bus.d_addr[1:0];
      wr_data = {4{bus.d_wdata[7:0]}};
    end
  end

  // Lane extraction for loads uses the width and low address bits captured at grant.
  always_comb begin
    rd_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    rd_byte = bus.mem_rdata[{r_lane, 3'b000} +: 8];
    rd_ext  = bus.mem_rdata;
    case (r_width)
      2'd1:    rd_ext = {{16{rd_half[15]}}, rd_half};
      2'd2:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      default: rd_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      wait_cnt       <= '0;
      r_is_d         <= 1'b0;
      r_we           <= 1'b0;
      r_width        <= 2'd0;
      r_lane         <= 2'd0;
      bus.if_ready   <= 1'b0;
      bus.if_rdata   <= '0;
      bus.d_ready    <= 1'b0;
      bus.d_rdata    <= '0;
      bus.d_misalign <= 1'b0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_be     <= 4'b0000;
      bus.mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            r_is_d       <= grant_d;
            r_we         <= grant_we;
            r_width      <= grant_d ? bus.d_width : 2'd0;
            r_lane       <= grant_d ? bus.d_addr[1:0] : bus.if_addr[1:0];
            bus.mem_addr <= grant_d ? bus.d_addr[31:2] : bus.if_addr[31:2];
            if (grant_if)
              starve_cnt <= '0;
            else if (bus.if_req && (starve_cnt != SW'(STARVE_MAX)))
              starve_cnt <= starve_cnt + 1'b1;
            if (grant_d && misalign) begin
              state          <= RESP;
              bus.d_ready    <= 1'b1;
              bus.d_misalign <= 1'b1;
              bus.d_rdata    <= '0;
            end else begin
              state      <= ISSUE;
              bus.mem_en <= 1'b1;
              bus.mem_we <= grant_we;
              bus.mem_be <= grant_we ? wr_be : 4'b1111;
              if (grant_we)
                bus.mem_wdata <= wr_data;
            end
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.mem_be <= 4'b0000;
          wait_cnt   <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == CW'(MEM_LAT - 1)) begin
            state <= RESP;
            if (r_is_d) begin
              bus.d_ready <= 1'b1;
              if (!r_we)
                bus.d_rdata <= rd_ext;
            end else begin
              bus.if_ready <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          bus.if_ready   <= 1'b0;
          bus.d_ready    <= 1'b0;
          bus.d_misalign <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
